// File: rtl/imem_load_arbiter.sv
// Shares the instruction-memory port between fetch and an external program loader.
// Writes are combinational in BOOT/LOAD; a reload pauses, flushes and drains the core first.
module imem_load_arbiter #(
    parameter int          IMEM_DEPTH   = 256,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_stall_i,
    input  logic                          ld_valid,
    input  logic [31:0]                   ld_addr,
    input  logic [31:0]                   ld_data,
    input  logic                          ld_done,
    output logic                          ld_ready,
    output logic                          imem_read_en,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    output logic [31:0]                   imem_wdata,
    output logic                          core_hold,
    output logic                          flush_req,
    output logic                          pc_restart_en,
    output logic [31:0]                   pc_restart_addr,
    output logic [$clog2(IMEM_DEPTH):0]   load_count,
    output logic                          ld_err,
    output logic [2:0]                    arb_state
);

    localparam int             AW         = $clog2(IMEM_DEPTH);
    localparam logic [29:0]    DEPTH_W    = 30'(IMEM_DEPTH);
    localparam logic [3:0]     DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [AW:0]    COUNT_MAX  = (AW+1)'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        LOAD    = 3'd3,
        RESTART = 3'd4
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_drain_cnt, w_drain_nxt;
    logic        r_flush_req, w_flush_nxt;
    logic [AW:0] r_load_count, w_load_count_nxt;
    logic        r_ld_err, w_ld_err_nxt;

    logic w_ld_ready;
    logic w_accept;
    logic w_addr_ok;
    logic w_we;

    assign w_ld_ready = (r_state == BOOT) || (r_state == LOAD);
    assign w_accept   = ld_valid & w_ld_ready;
    assign w_addr_ok  = (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < DEPTH_W);
    assign w_we       = w_accept & w_addr_ok;

    always_comb begin
        w_next           = r_state;
        w_drain_nxt      = r_drain_cnt;
        w_flush_nxt      = 1'b0;
        w_load_count_nxt = r_load_count;
        w_ld_err_nxt     = r_ld_err;

        if (w_we && (r_load_count != COUNT_MAX)) begin
            w_load_count_nxt = r_load_count + 1'b1;
        end
        if (w_accept && !w_addr_ok) begin
            w_ld_err_nxt = 1'b1;
        end

        case (r_state)
            BOOT, LOAD: begin
                if (ld_done) begin
                    w_next      = RESTART;
                    w_flush_nxt = 1'b1;
                end
            end
            RUN: begin
                // The loader's word is not taken here; it must be held until LOAD.
                if (ld_valid) begin
                    w_next      = DRAIN;
                    w_drain_nxt = 4'd0;
                    w_flush_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_next           = LOAD;
                    w_drain_nxt      = 4'd0;
                    w_load_count_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain_cnt + 4'd1;
                end
            end
            RESTART: begin
                w_next = RUN;
            end
            default: begin
                w_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= BOOT;
            r_drain_cnt  <= 4'd0;
            r_flush_req  <= 1'b0;
            r_load_count <= '0;
            r_ld_err     <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_drain_cnt  <= w_drain_nxt;
            r_flush_req  <= w_flush_nxt;
            r_load_count <= w_load_count_nxt;
            r_ld_err     <= w_ld_err_nxt;
        end
    end

    assign ld_ready        = w_ld_ready;
    assign core_hold       = (r_state != RUN);
    assign imem_read_en    = (r_state == RUN) & ~fetch_stall_i;
    assign imem_we         = w_we;
    assign imem_waddr      = ld_addr[2 +: AW];
    assign imem_wdata      = ld_data;
    assign flush_req       = r_flush_req;
    assign pc_restart_en   = (r_state == RESTART);
    assign pc_restart_addr = RESET_PC;
    assign load_count      = r_load_count;
    assign ld_err          = r_ld_err;
    assign arb_state       = r_state;

endmodule
